// File: rtl/calc_input_fsm.sv
// calc_input_fsm: key-entry sequencer for the calculator.
// It turns extended-BCD keys into operand/operator transactions, starts the
// calculator, latches its result, and selects the signed value to display.
// Optional feature macro: CALC_CHAIN_EN. When it is defined, an operator key
// pressed while a good result is shown continues the calculation, using that
// result as the new operand1.
//
// Handshakes: key_valid and result_valid are single-cycle strobes. Neither
// has a ready signal, so each is consumed on the sw_clk edge where it is high.
// calc_start is a single-cycle strobe that this block raises toward the
// calculator. operand1, operand2 and operator are stable while it is high and
// stay stable until the result returns.
module calc_input_fsm #(
    parameter int MAX_DIGITS = 9
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  ebcd,
    input  logic [31:0] result,
    input  logic        result_valid,
    input  logic        calc_err,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  operator,
    output logic        calc_start,
    output logic [31:0] fnd_serial,
    output logic        err,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_OP1  = 3'd0;
    localparam logic [2:0] S_OPR  = 3'd1;
    localparam logic [2:0] S_OP2  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4;

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    logic [2:0]    state;
    logic          sign_bit;
    logic [30:0]   buffer;
    logic [CW-1:0] count;
    logic [31:0]   result_q;
    // Set once an operator key has been pressed while in S_OPR. After that,
    // '-' negates operand2 instead of replacing the operator.
    logic          opr_pressed;

    logic          key_digit;
    logic          key_op;
    logic          key_minus;
    logic          key_eq;
    logic          key_clr;
    logic          can_accum;
    logic [30:0]   digit_val;
    logic [30:0]   buffer_next;
    logic [2:0]    op_code;
    logic [31:0]   entry_value;

    assign key_digit   = key_valid && (ebcd <= 4'd9);
    assign key_op      = key_valid && (ebcd >= 4'd10) && (ebcd <= 4'd13);
    assign key_minus   = key_valid && (ebcd == 4'd11);
    assign key_eq      = key_valid && (ebcd == 4'd14);
    assign key_clr     = key_valid && (ebcd == 4'd15);
    assign can_accum   = (count < MAX_CNT);
    assign digit_val   = {27'd0, ebcd};
    assign buffer_next = (buffer * 31'd10) + digit_val;
    assign op_code     = 3'(ebcd - 4'd9);
    assign entry_value = sign_bit ? -{1'b0, buffer} : {1'b0, buffer};
    assign state_dbg   = state;

    // Sequencer: key decoding, operand/operator latching and result capture.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state       <= S_OP1;
            sign_bit    <= 1'b0;
            buffer      <= '0;
            count       <= '0;
            operand1    <= '0;
            operand2    <= '0;
            operator    <= '0;
            calc_start  <= 1'b0;
            err         <= 1'b0;
            result_q    <= '0;
            opr_pressed <= 1'b0;
        end else begin
            calc_start <= 1'b0;
            if (key_clr) begin
                state       <= S_OP1;
                sign_bit    <= 1'b0;
                buffer      <= '0;
                count       <= '0;
                operand1    <= '0;
                operand2    <= '0;
                operator    <= '0;
                err         <= 1'b0;
                result_q    <= '0;
                opr_pressed <= 1'b0;
            end else begin
                case (state)
                    S_OP1: begin
                        if (key_digit) begin
                            if (can_accum) begin
                                buffer <= buffer_next;
                                count  <= count + 1'b1;
                            end
                        end else if (key_minus && (count == '0)) begin
                            sign_bit <= ~sign_bit;
                        end else if (key_op && (count != '0)) begin
                            operand1    <= entry_value;
                            operator    <= op_code;
                            buffer      <= '0;
                            count       <= '0;
                            sign_bit    <= 1'b0;
                            opr_pressed <= 1'b0;
                            state       <= S_OPR;
                        end
                    end
                    S_OPR: begin
                        if (key_digit) begin
                            buffer <= buffer_next;
                            count  <= count + 1'b1;
                            state  <= S_OP2;
                        end else if (key_op) begin
                            if (key_minus && opr_pressed) begin
                                sign_bit <= ~sign_bit;
                            end else begin
                                operator    <= op_code;
                                opr_pressed <= 1'b1;
                            end
                        end
                    end
                    S_OP2: begin
                        if (key_digit) begin
                            if (can_accum) begin
                                buffer <= buffer_next;
                                count  <= count + 1'b1;
                            end
                        end else if (key_eq) begin
                            operand2   <= entry_value;
                            calc_start <= 1'b1;
                            buffer     <= '0;
                            count      <= '0;
                            sign_bit   <= 1'b0;
                            state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (result_valid) begin
                            if (calc_err) begin
                                err <= 1'b1;
                            end else begin
                                result_q <= result;
                            end
                            state <= S_RES;
                        end
                    end
                    S_RES: begin
                        if (key_digit) begin
                            operand1 <= '0;
                            operand2 <= '0;
                            operator <= '0;
                            err      <= 1'b0;
                            buffer   <= digit_val;
                            count    <= CW'(1);
                            sign_bit <= 1'b0;
                            state    <= S_OP1;
                        end
`ifdef CALC_CHAIN_EN
                        else if (key_op && !err) begin
                            operand1    <= result_q;
                            operator    <= op_code;
                            buffer      <= '0;
                            count       <= '0;
                            sign_bit    <= 1'b0;
                            opr_pressed <= 1'b0;
                            state       <= S_OPR;
                        end
`endif
                    end
                    default: state <= S_OP1;
                endcase
            end
        end
    end

    // Display selection: what the user is typing, or the relevant latched value.
    always_comb begin
        fnd_serial = '0;
        case (state)
            S_OP1, S_OP2: fnd_serial = entry_value;
            S_OPR:        fnd_serial = operand1;
            S_WAIT:       fnd_serial = operand2;
            S_RES:        fnd_serial = err ? 32'd0 : result_q;
            default:      fnd_serial = '0;
        endcase
    end

endmodule

// File: tb/tb_calc_input_fsm.sv
// Bench for calc_input_fsm. It runs a vector table, some hand-written
// sequences and randomized keys, which are checked against a reference model.
module tb_calc_input_fsm;

  localparam int MAX_DIGITS = 9;

  logic        sw_clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  ebcd;
  logic [31:0] result;
  logic        result_valid;
  logic        calc_err;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  operator;
  logic        calc_start;
  logic [31:0] fnd_serial;
  logic        err;
  logic [2:0]  state_dbg;

  int n_pass;
  int n_total;

  calc_input_fsm #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .sw_clk(sw_clk),
    .rst(rst),
    .key_valid(key_valid),
    .ebcd(ebcd),
    .result(result),
    .result_valid(result_valid),
    .calc_err(calc_err),
    .operand1(operand1),
    .operand2(operand2),
    .operator(operator),
    .calc_start(calc_start),
    .fnd_serial(fnd_serial),
    .err(err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial sw_clk = 1'b0;
  always #5 sw_clk = ~sw_clk;

  // ---------------- reference model ----------------
  localparam int P_FIRST  = 10;
  localparam int P_OPSEL  = 11;
  localparam int P_SECOND = 12;
  localparam int P_BUSY   = 13;
  localparam int P_SHOW   = 14;

  int     m_phase;
  bit     m_neg;
  longint m_mag;
  int     m_ndig;
  longint m_a;
  longint m_b;
  int     m_op;
  longint m_res;
  bit     m_err;
  bit     m_start;
  bit     m_pressed;

  task automatic model_reset();
    m_phase = P_FIRST; m_neg = 0; m_mag = 0; m_ndig = 0;
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0; m_start = 0; m_pressed = 0;
  endtask

  function automatic longint m_entry();
    return m_neg ? -m_mag : m_mag;
  endfunction

  task automatic m_clear_entry();
    m_neg = 0; m_mag = 0; m_ndig = 0;
  endtask

  task automatic m_add_digit(input int d);
    if (m_ndig < MAX_DIGITS) begin
      m_mag = m_mag * 10 + d;
      m_ndig++;
    end
  endtask

  task automatic model_step(input bit kv, input int k, input bit rv, input logic [31:0] r, input bit ce);
    bit is_digit;
    bit is_op;
    is_digit = kv && (k <= 9);
    is_op    = kv && (k >= 10) && (k <= 13);
    m_start  = 0;
    if (kv && k == 15) begin
      model_reset();
    end else begin
      case (m_phase)
        P_FIRST: begin
          if (is_digit) m_add_digit(k);
          else if (kv && k == 11 && m_ndig == 0) m_neg = !m_neg;
          else if (is_op && m_ndig > 0) begin
            m_a = m_entry(); m_op = k - 9; m_clear_entry(); m_pressed = 0; m_phase = P_OPSEL;
          end
        end
        P_OPSEL: begin
          if (is_digit) begin
            m_add_digit(k); m_phase = P_SECOND;
          end else if (is_op) begin
            if (k == 11 && m_pressed) m_neg = !m_neg;
            else begin m_op = k - 9; m_pressed = 1; end
          end
        end
        P_SECOND: begin
          if (is_digit) m_add_digit(k);
          else if (kv && k == 14) begin
            m_b = m_entry(); m_start = 1; m_clear_entry(); m_phase = P_BUSY;
          end
        end
        P_BUSY: begin
          if (rv) begin
            if (ce) m_err = 1;
            else m_res = longint'($signed(r));
            m_phase = P_SHOW;
          end
        end
        P_SHOW: begin
          if (is_digit) begin
            m_a = 0; m_b = 0; m_op = 0; m_err = 0;
            m_clear_entry(); m_add_digit(k); m_phase = P_FIRST;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op && !m_err) begin
            m_a = m_res; m_op = k - 9; m_clear_entry(); m_pressed = 0; m_phase = P_OPSEL;
          end
`endif
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_fnd();
    longint v;
    case (m_phase)
      P_OPSEL: v = m_a;
      P_BUSY:  v = m_b;
      P_SHOW:  v = m_err ? 0 : m_res;
      default: v = m_entry();
    endcase
    return v[31:0];
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] e_op1, input logic [31:0] e_op2,
                             input logic [2:0] e_opr, input bit e_start, input logic [31:0] e_fnd,
                             input bit e_err);
    chk({tag, ".operand1"},   operand1,            e_op1);
    chk({tag, ".operand2"},   operand2,            e_op2);
    chk({tag, ".operator"},   {29'd0, operator},   {29'd0, e_opr});
    chk({tag, ".calc_start"}, {31'd0, calc_start}, {31'd0, e_start});
    chk({tag, ".fnd_serial"}, fnd_serial,          e_fnd);
    chk({tag, ".err"},        {31'd0, err},        {31'd0, e_err});
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] a;
    logic [31:0] b;
    a = m_a[31:0];
    b = m_b[31:0];
    chk_outputs(tag, a, b, 3'(m_op), m_start, m_fnd(), m_err);
  endtask

  // ---------------- driver ----------------
  // Inputs are applied 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive(input bit kv, input logic [3:0] k, input bit rv, input logic [31:0] r, input bit ce);
    key_valid = kv; ebcd = k; result_valid = rv; result = r; calc_err = ce;
    @(posedge sw_clk);
    #1;
    model_step(kv, int'(k), rv, r, ce);
    key_valid = 0; result_valid = 0; calc_err = 0;
  endtask

  task automatic key(input logic [3:0] k);
    drive(1'b1, k, 1'b0, 32'd0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          kv;
    logic [3:0]  k;
    bit          rv;
    logic [31:0] r;
    bit          ce;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [2:0]  e_opr;
    bit          e_start;
    logic [31:0] e_fnd;
    bit          e_err;
  } vec_t;

  function automatic vec_t mk(input bit kv, input int k, input bit rv, input int r, input bit ce,
                              input int op1, input int op2, input int opr, input bit st,
                              input int fnd, input bit e);
    vec_t v;
    v.kv = kv; v.k = 4'(k); v.rv = rv; v.r = 32'(r); v.ce = ce;
    v.e_op1 = 32'(op1); v.e_op2 = 32'(op2); v.e_opr = 3'(opr); v.e_start = st;
    v.e_fnd = 32'(fnd); v.e_err = e;
    return v;
  endfunction

  vec_t vecs[23];

  initial begin
    n_pass = 0;
    n_total = 0;
    //          kv  k rv    r ce   op1 op2 opr st  fnd err
    vecs[0]  = mk(1,  1, 0,   0, 0,   0,  0, 0, 0,   1, 0);
    vecs[1]  = mk(1,  2, 0,   0, 0,   0,  0, 0, 0,  12, 0);
    vecs[2]  = mk(1, 10, 0,   0, 0,  12,  0, 1, 0,  12, 0);
    vecs[3]  = mk(1,  3, 0,   0, 0,  12,  0, 1, 0,   3, 0);
    vecs[4]  = mk(1, 14, 0,   0, 0,  12,  3, 1, 1,   3, 0);
    vecs[5]  = mk(0,  0, 0,   0, 0,  12,  3, 1, 0,   3, 0);
    vecs[6]  = mk(1,  5, 0,   0, 0,  12,  3, 1, 0,   3, 0);
    vecs[7]  = mk(0,  0, 1,  15, 0,  12,  3, 1, 0,  15, 0);
    vecs[8]  = mk(1, 15, 0,   0, 0,   0,  0, 0, 0,   0, 0);
    vecs[9]  = mk(1, 11, 0,   0, 0,   0,  0, 0, 0,   0, 0);
    vecs[10] = mk(1,  7, 0,   0, 0,   0,  0, 0, 0,  -7, 0);
    vecs[11] = mk(1, 12, 0,   0, 0,  -7,  0, 3, 0,  -7, 0);
    vecs[12] = mk(1,  2, 0,   0, 0,  -7,  0, 3, 0,   2, 0);
    vecs[13] = mk(1, 14, 0,   0, 0,  -7,  2, 3, 1,   2, 0);
    vecs[14] = mk(0,  0, 1, -14, 0,  -7,  2, 3, 0, -14, 0);
    vecs[15] = mk(1, 15, 0,   0, 0,   0,  0, 0, 0,   0, 0);
    vecs[16] = mk(1,  8, 0,   0, 0,   0,  0, 0, 0,   8, 0);
    vecs[17] = mk(1, 13, 0,   0, 0,   8,  0, 4, 0,   8, 0);
    vecs[18] = mk(1,  0, 0,   0, 0,   8,  0, 4, 0,   0, 0);
    vecs[19] = mk(1, 14, 0,   0, 0,   8,  0, 4, 1,   0, 0);
    vecs[20] = mk(0,  0, 1, 123, 1,   8,  0, 4, 0,   0, 1);
    vecs[21] = mk(1,  5, 0,   0, 0,   0,  0, 0, 0,   5, 0);
    vecs[22] = mk(1, 15, 0,   0, 0,   0,  0, 0, 0,   0, 0);

    // reset
    rst = 1'b0; key_valid = 0; ebcd = 0; result = 0; result_valid = 0; calc_err = 0;
    model_reset();
    repeat (3) @(posedge sw_clk);
    #1;
    rst = 1'b1;
    chk_outputs("reset", 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);

    // table-driven vectors
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].kv, vecs[i].k, vecs[i].rv, vecs[i].r, vecs[i].ce);
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_opr,
                  vecs[i].e_start, vecs[i].e_fnd, vecs[i].e_err);
    end

    // ten nines: the tenth digit is dropped
    for (int i = 0; i < 10; i++) key(4'd9);
    chk("ten_nines.fnd", fnd_serial, 32'd999999999);
    key(4'd10);
    chk("ten_nines.op1", operand1, 32'd999999999);
    key(4'd15);

    // result shown, then '-', 4, '='
    key(4'd1); key(4'd2); key(4'd10); key(4'd3); key(4'd14);
    drive(1'b0, 4'd0, 1'b1, 32'd15, 1'b0);
    chk("res15.fnd", fnd_serial, 32'd15);
    chk("res15.state_is_res", {29'd0, state_dbg}, 32'd4);
    key(4'd11); key(4'd4); key(4'd14);
`ifdef CALC_CHAIN_EN
    chk_outputs("chain", 32'd15, 32'd4, 3'd2, 1'b1, 32'd4, 1'b0);
`else
    chk_outputs("nochain", 32'd0, 32'd0, 3'd0, 1'b0, 32'd4, 1'b0);
`endif
    key(4'd15);

    // first operator press in S_OPR replaces, a later '-' negates operand2
    key(4'd5); key(4'd12); key(4'd11);
    chk("opr_replace.op", {29'd0, operator}, 32'd2);
    key(4'd15);
    key(4'd5); key(4'd12); key(4'd12); key(4'd11); key(4'd3); key(4'd14);
    chk_outputs("opr_negate", 32'd5, 32'hFFFF_FFFD, 3'd3, 1'b1, 32'hFFFF_FFFD, 1'b0);

    // CLR coincident with result_valid, then a late result
    drive(1'b1, 4'd15, 1'b1, 32'd77, 1'b0);
    chk_outputs("clr_vs_res", 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 32'd88, 1'b0);
    chk_outputs("late_res", 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);

    // asynchronous reset mid-transaction drops the pending result
    key(4'd6); key(4'd12); key(4'd7); key(4'd14);
    rst = 1'b0;
    #2;
    chk_outputs("async_rst", 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    model_reset();
    drive(1'b0, 4'd0, 1'b1, 32'd42, 1'b0);
    chk_outputs("rst_drop", 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);

    // randomized keys and results against the model
    for (int i = 0; i < 2000; i++) begin
      bit          kv;
      logic [3:0]  k;
      bit          rv;
      bit          ce;
      int          p;
      kv = ($urandom_range(0, 99) < 60);
      p = $urandom_range(0, 99);
      if (p < 50)      k = 4'($urandom_range(0, 9));
      else if (p < 80) k = 4'($urandom_range(10, 13));
      else if (p < 96) k = 4'd14;
      else             k = 4'd15;
      rv = ($urandom_range(0, 9) == 0) || (m_phase == P_BUSY && $urandom_range(0, 3) == 0);
      ce = ($urandom_range(0, 4) == 0);
      drive(kv, k, rv, $urandom, ce);
      chk_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
